beta_pipe_ctrl: RTL and testbench

Global Pipeline Control Unit for the beta core. It drives the stall and flush inputs of the fetch/decode, decode/execute and execute/writeback pipeline registers and the PC register. It resolves load-use hazards, instruction-memory starvation, data-memory wait states and taken-branch squashing. A small FSM with a penalty counter and a wait-timeout counter tracks the multi-cycle cases.

---
 rtl/beta_pipe_ctrl.sv | 130 +++++++++++++
 tb/tb_beta_pipe_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/beta_pipe_ctrl.sv
// beta_pipe_ctrl: global stall/flush control for the beta core pipeline registers and PC
module beta_pipe_ctrl #(
    parameter int BranchPenalty = 2,
    parameter int MemTimeout    = 255
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [4:0] dec_rs1_addr_i,
    input  logic [4:0] dec_rs2_addr_i,
    input  logic       dec_rs1_used_i,
    input  logic       dec_rs2_used_i,
    input  logic [4:0] exe_rd_addr_i,
    input  logic       exe_load_i,
    input  logic       exe_branch_taken_i,
    input  logic       lsu_req_i,
    input  logic       lsu_ack_i,
    input  logic       imem_valid_i,
    output logic       pc_stall_o,
    output logic       if_dec_stall_o,
    output logic       if_dec_flush_o,
    output logic       dec_exe_stall_o,
    output logic       dec_exe_flush_o,
    output logic       exe_wb_stall_o,
    output logic [1:0] ctrl_state_o,
    output logic       mem_timeout_o
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;
    localparam logic [3:0]  PEN_LOAD = 4'(BranchPenalty - 1);
    localparam logic [15:0] TO_MAX   = 16'(MemTimeout);
    state_t      state, state_nxt;
    logic [3:0]  pen_cnt, pen_nxt;
    logic [15:0] to_cnt, to_nxt;
    logic        timeout_q, timeout_nxt;
    logic        hazard, mem_miss;
    assign hazard = exe_load_i && (exe_rd_addr_i != 5'd0) &&
                    ((dec_rs1_used_i && (dec_rs1_addr_i == exe_rd_addr_i)) ||
                     (dec_rs2_used_i && (dec_rs2_addr_i == exe_rd_addr_i)));
    assign mem_miss      = lsu_req_i && !lsu_ack_i;
    assign ctrl_state_o  = state;
    assign mem_timeout_o = timeout_q;
    // State, counters and sticky timeout flag
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= RUN;
            pen_cnt   <= 4'd0;
            to_cnt    <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            pen_cnt   <= pen_nxt;
            to_cnt    <= to_nxt;
            timeout_q <= timeout_nxt;
        end
    end
    // Next state: branch beats memory miss in RUN; MEM_WAIT and FLUSH ignore branches
    always_comb begin
        state_nxt   = state;
        pen_nxt     = pen_cnt;
        to_nxt      = to_cnt;
        timeout_nxt = timeout_q;
        case (state)
            RUN: begin
                if (exe_branch_taken_i) begin
                    if (BranchPenalty > 1) begin
                        state_nxt = FLUSH;
                        pen_nxt   = PEN_LOAD;
                    end
                end else if (mem_miss) begin
                    state_nxt = MEM_WAIT;
                    to_nxt    = 16'd0;
                end
            end
            MEM_WAIT: begin
                if (lsu_ack_i) begin
                    state_nxt = RUN;
                end else begin
                    to_nxt = (to_cnt < TO_MAX) ? to_cnt + 16'd1 : to_cnt;
                    if (to_nxt == TO_MAX) timeout_nxt = 1'b1;
                end
            end
            FLUSH: begin
                pen_nxt = pen_cnt - 4'd1;
                if (pen_cnt <= 4'd1) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end
    // Mealy stall/flush outputs, forced low while reset is held
    always_comb begin
        pc_stall_o      = 1'b0;
        if_dec_stall_o  = 1'b0;
        if_dec_flush_o  = 1'b0;
        dec_exe_stall_o = 1'b0;
        dec_exe_flush_o = 1'b0;
        exe_wb_stall_o  = 1'b0;
        if (rstn_i) begin
            case (state)
                RUN: begin
                    if (exe_branch_taken_i) begin
                        if_dec_flush_o  = 1'b1;
                        dec_exe_flush_o = 1'b1;
                    end else if (mem_miss) begin
                        pc_stall_o      = 1'b1;
                        if_dec_stall_o  = 1'b1;
                        dec_exe_stall_o = 1'b1;
                        exe_wb_stall_o  = 1'b1;
                    end else if (hazard) begin
                        pc_stall_o      = 1'b1;
                        if_dec_stall_o  = 1'b1;
                        dec_exe_flush_o = 1'b1;
                    end else if (!imem_valid_i) begin
                        pc_stall_o     = 1'b1;
                        if_dec_flush_o = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    pc_stall_o      = !lsu_ack_i;
                    if_dec_stall_o  = !lsu_ack_i;
                    dec_exe_stall_o = !lsu_ack_i;
                    exe_wb_stall_o  = !lsu_ack_i;
                end
                FLUSH: begin
                    if_dec_flush_o  = 1'b1;
                    dec_exe_flush_o = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_beta_pipe_ctrl.sv
// tb_beta_pipe_ctrl: table vectors, corner sequences and random stimulus against a reference model
module tb_beta_pipe_ctrl;
    localparam int BP = 2;
    localparam int MT = 4;
    localparam logic [5:0] O_BR  = 6'b001010;
    localparam logic [5:0] O_MEM = 6'b110101;
    localparam logic [5:0] O_LU  = 6'b110010;
    localparam logic [5:0] O_IV  = 6'b101000;

    logic clk = 1'b0, rstn = 1'b0;
    logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
    logic u1 = 0, u2 = 0, ld = 0, br = 0, req = 0, ack = 0, iv = 1;
    logic pc_stall, if_dec_stall, if_dec_flush, dec_exe_stall, dec_exe_flush, exe_wb_stall;
    logic [1:0] st;
    logic to;
    logic [5:0] outs;
    int total = 0, bad = 0;

    // reference model: remaining forced flush cycles, pending memory wait, stalled cycles seen
    int m_flush = 0;
    bit m_wait = 0;
    int m_waited = 0;
    bit m_to = 0;

    beta_pipe_ctrl #(.BranchPenalty(BP), .MemTimeout(MT)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .dec_rs1_addr_i(rs1), .dec_rs2_addr_i(rs2),
        .dec_rs1_used_i(u1), .dec_rs2_used_i(u2),
        .exe_rd_addr_i(rd), .exe_load_i(ld), .exe_branch_taken_i(br),
        .lsu_req_i(req), .lsu_ack_i(ack), .imem_valid_i(iv),
        .pc_stall_o(pc_stall), .if_dec_stall_o(if_dec_stall), .if_dec_flush_o(if_dec_flush),
        .dec_exe_stall_o(dec_exe_stall), .dec_exe_flush_o(dec_exe_flush),
        .exe_wb_stall_o(exe_wb_stall), .ctrl_state_o(st), .mem_timeout_o(to)
    );

    assign outs = {pc_stall, if_dec_stall, if_dec_flush, dec_exe_stall, dec_exe_flush, exe_wb_stall};

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic [4:0] rs1, rs2, rd;
        logic u1, u2, ld, br, req, ack, iv;
        logic [5:0] exp;
    } vec_t;

    function automatic vec_t mk(string n, logic [4:0] a, logic [4:0] b, logic ua, logic ub,
                                logic [4:0] d, logic l, logic bb, logic r, logic k, logic v,
                                logic [5:0] e);
        vec_t x;
        x.name = n; x.rs1 = a; x.rs2 = b; x.u1 = ua; x.u2 = ub; x.rd = d;
        x.ld = l; x.br = bb; x.req = r; x.ack = k; x.iv = v; x.exp = e;
        return x;
    endfunction

    function automatic bit m_hazard();
        return ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    endfunction

    function automatic logic [5:0] m_outs();
        if (m_flush > 0) return O_BR;
        if (m_wait) return ack ? 6'b0 : O_MEM;
        if (br) return O_BR;
        if (req && !ack) return O_MEM;
        if (m_hazard()) return O_LU;
        if (!iv) return O_IV;
        return 6'b0;
    endfunction

    function automatic logic [1:0] m_state();
        return (m_flush > 0) ? 2'd2 : m_wait ? 2'd1 : 2'd0;
    endfunction

    task automatic m_update();
        if (m_flush > 0) m_flush--;
        else if (m_wait) begin
            if (ack) m_wait = 0;
            else begin
                m_waited++;
                if (m_waited >= MT) m_to = 1;
            end
        end else if (br) m_flush = BP - 1;
        else if (req && !ack) begin
            m_wait = 1;
            m_waited = 0;
        end
    endtask

    task automatic m_reset();
        m_flush = 0; m_wait = 0; m_waited = 0; m_to = 0;
    endtask

    task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(logic [4:0] a, logic [4:0] b, logic ua, logic ub, logic [4:0] d,
                         logic l, logic bb, logic r, logic k, logic v);
        rs1 = a; rs2 = b; u1 = ua; u2 = ub; rd = d; ld = l; br = bb; req = r; ack = k; iv = v;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // inputs are applied at posedge+1; compare mid-cycle against constants, then advance
    task automatic tick_c(string nm, logic [5:0] eo, logic [1:0] es, logic et);
        #4;
        check({nm, ".outs"}, 16'(outs), 16'(eo));
        check({nm, ".state"}, 16'(st), 16'(es));
        check({nm, ".timeout"}, 16'(to), 16'(et));
        @(posedge clk);
        m_update();
        #1;
    endtask

    // same, but expectations come from the reference model
    task automatic tick(string nm);
        #4;
        check({nm, ".outs"}, 16'(outs), 16'(m_outs()));
        check({nm, ".state"}, 16'(st), 16'(m_state()));
        check({nm, ".timeout"}, 16'(to), 16'(m_to));
        @(posedge clk);
        m_update();
        #1;
    endtask

    initial begin
        vec_t tbl[10];
        tbl[0] = mk("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b0);
        tbl[1] = mk("lu_rs1",    5, 0, 1, 0, 5, 1, 0, 0, 0, 1, O_LU);
        tbl[2] = mk("after_lu",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b0);
        tbl[3] = mk("lu_x0",     0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 6'b0);
        tbl[4] = mk("lu_unused", 5, 0, 0, 0, 5, 1, 0, 0, 0, 1, 6'b0);
        tbl[5] = mk("lu_rs2",    1, 7, 1, 1, 7, 1, 0, 0, 0, 1, O_LU);
        tbl[6] = mk("no_load",   5, 0, 1, 0, 5, 0, 0, 0, 0, 1, 6'b0);
        tbl[7] = mk("imem_inv",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IV);
        tbl[8] = mk("req_ack",   0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6'b0);
        tbl[9] = mk("lu_vs_iv",  3, 0, 1, 0, 3, 1, 0, 0, 0, 0, O_LU);

        // reset holds every output low even with a hazard on the inputs
        drive(5, 0, 1, 0, 5, 1, 0, 1, 0, 0);
        repeat (2) @(posedge clk);
        #5;
        check("reset.outs", 16'(outs), 16'd0);
        check("reset.state", 16'(st), 16'd0);
        check("reset.timeout", 16'(to), 16'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle();

        foreach (tbl[i]) begin
            drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
                  tbl[i].ld, tbl[i].br, tbl[i].req, tbl[i].ack, tbl[i].iv);
            tick_c(tbl[i].name, tbl[i].exp, 2'd0, 1'b0);
        end

        // branch with a second pulse arriving during FLUSH
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        tick_c("br0", O_BR, 2'd0, 1'b0);
        tick_c("br1", O_BR, 2'd2, 1'b0);
        idle();
        tick_c("br2", 6'b0, 2'd0, 1'b0);

        // memory wait, ack three cycles after the request
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        tick_c("mw0", O_MEM, 2'd0, 1'b0);
        tick_c("mw1", O_MEM, 2'd1, 1'b0);
        tick_c("mw2", O_MEM, 2'd1, 1'b0);
        ack = 1'b1;
        tick_c("mw_ack", 6'b0, 2'd1, 1'b0);
        idle();
        tick_c("mw_done", 6'b0, 2'd0, 1'b0);

        // everything at once: branch wins, no stalls
        drive(4, 0, 1, 0, 4, 1, 1, 1, 0, 0);
        tick_c("prio0", O_BR, 2'd0, 1'b0);
        tick_c("prio1", O_BR, 2'd2, 1'b0);
        idle();
        tick_c("prio2", 6'b0, 2'd0, 1'b0);

        // timeout after four MEM_WAIT cycles, sticky past the ack
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 10; i++)
            tick_c("tmo", O_MEM, (i == 0) ? 2'd0 : 2'd1, i >= 5);
        ack = 1'b1;
        tick_c("tmo_ack", 6'b0, 2'd1, 1'b1);
        idle();
        tick_c("tmo_after", 6'b0, 2'd0, 1'b1);

        // asynchronous reset in the second MEM_WAIT cycle
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        tick_c("rst_mw0", O_MEM, 2'd0, 1'b1);
        tick_c("rst_mw1", O_MEM, 2'd1, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid.outs", 16'(outs), 16'd0);
        check("rst_mid.state", 16'(st), 16'd0);
        check("rst_mid.timeout", 16'(to), 16'd0);
        m_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive(5, 0, 1, 0, 5, 1, 0, 0, 0, 1);
        tick_c("rst_lu", O_LU, 2'd0, 1'b0);
        idle();
        tick_c("rst_idle", 6'b0, 2'd0, 1'b0);

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) != 0));
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
